// File: rtl/sccb_responder.sv
// SCCB slave-side responder.
// Watches the open-drain SIOC/SIOD bus, decodes start / device ID / register
// address / write data / stop, acknowledges matching transfers, issues a
// single-cycle register write strobe and serves 2-phase reads by shifting out
// the byte presented on rd_data.
module sccb_responder #(
    parameter logic [7:0] DEVICE_ADDR = 8'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SIOC_in,
    input  logic       SIOD_in,
    output logic       SIOD_oe,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy
);

    // Fewer than two synchronizer flops is never safe; clamp silently.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_DEV       = 4'd1;
    localparam logic [3:0] ST_DEV_ACK   = 4'd2;
    localparam logic [3:0] ST_REG       = 4'd3;
    localparam logic [3:0] ST_REG_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RD_NACK   = 4'd8;
    localparam logic [3:0] ST_WAIT_STOP = 4'd9;

    // Input conditioning
    logic [SYNC_N-1:0] r_sioc_sync;
    logic [SYNC_N-1:0] r_siod_sync;
    logic              r_sioc_hist;
    logic              r_siod_hist;

    logic w_sioc;
    logic w_siod;
    logic w_rise;
    logic w_fall;
    logic w_start;
    logic w_stop;

    // State and datapath registers
    logic [3:0] r_state;
    logic [3:0] r_bit_cnt;
    logic [6:0] r_rx;
    logic [7:0] r_tx;
    logic       r_rw;
    logic       r_siod_oe;
    logic       r_wr_en;
    logic [7:0] r_wr_addr;
    logic [7:0] r_wr_data;
    logic [7:0] r_rd_addr;
    logic       r_busy;

    // Next-state values
    logic [3:0] w_state_nxt;
    logic [3:0] w_bit_cnt_nxt;
    logic [6:0] w_rx_nxt;
    logic [7:0] w_tx_nxt;
    logic       w_rw_nxt;
    logic       w_oe_nxt;
    logic       w_wr_en_nxt;
    logic [7:0] w_wr_addr_nxt;
    logic [7:0] w_wr_data_nxt;
    logic [7:0] w_rd_addr_nxt;
    logic       w_busy_nxt;

    // Byte assembly helpers
    logic [7:0] w_byte;
    logic       w_bit_rise;
    logic       w_byte_done;
    logic       w_byte_end_fall;
    logic       w_id_match;

    // Bus idles high, so the synchronizers reset to 1 to avoid phantom edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sioc_sync <= {SYNC_N{1'b1}};
            r_siod_sync <= {SYNC_N{1'b1}};
        end else begin
            r_sioc_sync <= {r_sioc_sync[SYNC_N-2:0], SIOC_in};
            r_siod_sync <= {r_siod_sync[SYNC_N-2:0], SIOD_in};
        end
    end

    // One-cycle history of the synchronized lines for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sioc_hist <= 1'b1;
            r_siod_hist <= 1'b1;
        end else begin
            r_sioc_hist <= w_sioc;
            r_siod_hist <= w_siod;
        end
    end

    assign w_sioc  = r_sioc_sync[SYNC_N-1];
    assign w_siod  = r_siod_sync[SYNC_N-1];
    assign w_rise  = w_sioc & ~r_sioc_hist;
    assign w_fall  = ~w_sioc & r_sioc_hist;
    // Start/stop require SIOC high on both samples so a clock edge coinciding
    // with a data change is never mistaken for a bus condition.
    assign w_start = w_sioc & r_sioc_hist & r_siod_hist & ~w_siod;
    assign w_stop  = w_sioc & r_sioc_hist & ~r_siod_hist & w_siod;

    assign w_byte          = {r_rx, w_siod};
    assign w_bit_rise      = w_rise && (r_bit_cnt < 4'd8);
    assign w_byte_done     = w_rise && (r_bit_cnt == 4'd7);
    assign w_byte_end_fall = w_fall && (r_bit_cnt == 4'd8);
    assign w_id_match      = (w_byte[7:1] == DEVICE_ADDR[7:1]);

    // Protocol FSM: start/stop override everything, then per-state bit handling.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_rx_nxt      = r_rx;
        w_tx_nxt      = r_tx;
        w_rw_nxt      = r_rw;
        w_oe_nxt      = r_siod_oe;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_rd_addr_nxt = r_rd_addr;
        w_busy_nxt    = r_busy;

        if (w_start) begin
            // Start or repeated start: always restart device-ID reception.
            w_state_nxt   = ST_DEV;
            w_bit_cnt_nxt = 4'd0;
            w_oe_nxt      = 1'b0;
            w_busy_nxt    = 1'b1;
        end else if (w_stop && (r_state != ST_IDLE)) begin
            // Stop aborts any partial byte; nothing is strobed.
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = 4'd0;
            w_oe_nxt      = 1'b0;
            w_busy_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_oe_nxt   = 1'b0;
                    w_busy_nxt = 1'b0;
                end

                ST_DEV: begin
                    if (w_bit_rise) begin
                        w_rx_nxt      = w_byte[6:0];
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (w_byte_done) begin
                            w_rw_nxt = w_byte[0];
                            if (!w_id_match) begin
                                // Not addressed: stay silent until stop.
                                w_state_nxt = ST_WAIT_STOP;
                                w_busy_nxt  = 1'b0;
                            end else begin
                                w_state_nxt = ST_DEV;
                            end
                        end else begin
                            w_state_nxt = ST_DEV;
                        end
                    end else if (w_byte_end_fall) begin
                        w_state_nxt = ST_DEV_ACK;
                        w_oe_nxt    = 1'b1;
                        w_tx_nxt    = rd_data;
                    end else begin
                        w_state_nxt = ST_DEV;
                    end
                end

                ST_DEV_ACK: begin
                    if (w_fall) begin
                        w_bit_cnt_nxt = 4'd0;
                        if (r_rw) begin
                            // First read bit goes out on the same falling edge.
                            w_state_nxt = ST_RDATA;
                            w_oe_nxt    = ~r_tx[7];
                            w_tx_nxt    = {r_tx[6:0], 1'b0};
                        end else begin
                            w_state_nxt = ST_REG;
                            w_oe_nxt    = 1'b0;
                        end
                    end else begin
                        w_state_nxt = ST_DEV_ACK;
                    end
                end

                ST_REG: begin
                    if (w_bit_rise) begin
                        w_rx_nxt      = w_byte[6:0];
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (w_byte_done) begin
                            w_rd_addr_nxt = w_byte;
                            w_wr_addr_nxt = w_byte;
                        end else begin
                            w_rd_addr_nxt = r_rd_addr;
                        end
                    end else if (w_byte_end_fall) begin
                        w_state_nxt = ST_REG_ACK;
                        w_oe_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = ST_REG;
                    end
                end

                ST_REG_ACK: begin
                    if (w_fall) begin
                        w_state_nxt   = ST_WDATA;
                        w_bit_cnt_nxt = 4'd0;
                        w_oe_nxt      = 1'b0;
                    end else begin
                        w_state_nxt = ST_REG_ACK;
                    end
                end

                ST_WDATA: begin
                    if (w_bit_rise) begin
                        w_rx_nxt      = w_byte[6:0];
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (w_byte_done) begin
                            w_wr_data_nxt = w_byte;
                            w_wr_en_nxt   = 1'b1;
                        end else begin
                            w_wr_en_nxt = 1'b0;
                        end
                    end else if (w_byte_end_fall) begin
                        w_state_nxt = ST_WDATA_ACK;
                        w_oe_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = ST_WDATA;
                    end
                end

                ST_WDATA_ACK: begin
                    if (w_fall) begin
                        w_state_nxt   = ST_WAIT_STOP;
                        w_bit_cnt_nxt = 4'd0;
                        w_oe_nxt      = 1'b0;
                    end else begin
                        w_state_nxt = ST_WDATA_ACK;
                    end
                end

                ST_RDATA: begin
                    if (w_bit_rise) begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_byte_end_fall) begin
                        // Byte fully shifted: release for the master's NA bit.
                        w_state_nxt = ST_RD_NACK;
                        w_oe_nxt    = 1'b0;
                    end else if (w_fall) begin
                        w_oe_nxt = ~r_tx[7];
                        w_tx_nxt = {r_tx[6:0], 1'b0};
                    end else begin
                        w_state_nxt = ST_RDATA;
                    end
                end

                ST_RD_NACK: begin
                    if (w_fall) begin
                        w_state_nxt   = ST_WAIT_STOP;
                        w_bit_cnt_nxt = 4'd0;
                    end else begin
                        w_state_nxt = ST_RD_NACK;
                    end
                end

                ST_WAIT_STOP: begin
                    w_oe_nxt = 1'b0;
                end

                default: begin
                    w_state_nxt   = ST_IDLE;
                    w_bit_cnt_nxt = 4'd0;
                    w_oe_nxt      = 1'b0;
                    w_busy_nxt    = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset releases SIOD asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 4'd0;
            r_rx      <= 7'd0;
            r_tx      <= 8'd0;
            r_rw      <= 1'b0;
            r_siod_oe <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 8'h00;
            r_wr_data <= 8'h00;
            r_rd_addr <= 8'h00;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_rx      <= w_rx_nxt;
            r_tx      <= w_tx_nxt;
            r_rw      <= w_rw_nxt;
            r_siod_oe <= w_oe_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign SIOD_oe = r_siod_oe;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign rd_addr = r_rd_addr;
    assign busy    = r_busy;

endmodule

// File: tb/tb_sccb_responder.sv
// Directed testbench for sccb_responder: a bus master model drives SIOC/SIOD,
// the wired-AND bus combines it with the responder's pulldown.
module tb_sccb_responder;

    localparam int Q = 10;  // clk cycles per quarter SCCB bit

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m_sioc;
    logic       m_siod;
    logic       SIOC_in;
    logic       SIOD_in;
    logic       SIOD_oe;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;

    int vecs = 0;
    int errs = 0;
    int wr_cnt = 0;
    int oe_cnt = 0;
    logic [7:0] cap_addr = 8'h00;
    logic [7:0] cap_data = 8'h00;

    sccb_responder #(.DEVICE_ADDR(8'h42), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SIOC_in (SIOC_in),
        .SIOD_in (SIOD_in),
        .SIOD_oe (SIOD_oe),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy)
    );

    always #10 clk = ~clk;

    assign SIOC_in = m_sioc;
    assign SIOD_in = m_siod & ~SIOD_oe;

    // Count strobe cycles and pulldown cycles, capture strobe payload.
    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt   <= wr_cnt + 1;
            cap_addr <= wr_addr;
            cap_data <= wr_data;
        end
        if (SIOD_oe) oe_cnt <= oe_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_q;
        repeat (Q) @(posedge clk);
    endtask

    task automatic bus_start;
        m_siod = 1'b1; wait_q;
        m_sioc = 1'b1; wait_q;
        m_siod = 1'b0; wait_q;
        m_sioc = 1'b0; wait_q;
    endtask

    task automatic bus_stop;
        m_siod = 1'b0; wait_q;
        m_sioc = 1'b1; wait_q;
        m_siod = 1'b1; wait_q;
    endtask

    task automatic send_bit(input logic b);
        m_siod = b;    wait_q;
        m_sioc = 1'b1; wait_q; wait_q;
        m_sioc = 1'b0; wait_q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        m_siod = 1'b1; wait_q;
        m_sioc = 1'b1; wait_q;
        @(negedge clk);
        ack = SIOD_oe;
        wait_q;
        m_sioc = 1'b0; wait_q;
    endtask

    task automatic read_byte(output logic [7:0] d, output logic [7:0] oeb, output logic na_oe);
        m_siod = 1'b1;
        d = 8'h00;
        oeb = 8'h00;
        for (int i = 0; i < 8; i++) begin
            wait_q;
            m_sioc = 1'b1; wait_q;
            @(negedge clk);
            d   = {d[6:0], SIOD_in};
            oeb = {oeb[6:0], SIOD_oe};
            wait_q;
            m_sioc = 1'b0; wait_q;
        end
        wait_q;
        m_sioc = 1'b1; wait_q;
        @(negedge clk);
        na_oe = SIOD_oe;
        wait_q;
        m_sioc = 1'b0; wait_q;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; m_sioc = 1'b1; m_siod = 1'b1; rd_data = 8'h00;
        repeat (5) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        vecs++; if (SIOD_oe !== 1'b0) begin errs++; $display("FAIL reset_oe: got %b want 0", SIOD_oe); end
        vecs++; if (wr_en !== 1'b0) begin errs++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
        vecs++; if ({wr_addr, wr_data, rd_addr} !== 24'h000000) begin errs++; $display("FAIL reset_regs: got %h want 000000", {wr_addr, wr_data, rd_addr}); end
    endtask

    task automatic test_three_phase_write;
        logic a0, a1, a2;
        int wr0;
        wr0 = wr_cnt;
        bus_start;
        write_byte(8'h42, a0); write_byte(8'h12, a1); write_byte(8'h80, a2);
        @(negedge clk);
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL w3_busy_before_stop: got %b want 1", busy); end
        bus_stop; wait_q;
        vecs++; if ({a0, a1, a2} !== 3'b111) begin errs++; $display("FAIL w3_acks: got %b want 111", {a0, a1, a2}); end
        vecs++; if (wr_cnt - wr0 != 1) begin errs++; $display("FAIL w3_wr_en_cycles: got %0d want 1", wr_cnt - wr0); end
        vecs++; if ({cap_addr, cap_data} !== 16'h1280) begin errs++; $display("FAIL w3_strobe_payload: got %h want 1280", {cap_addr, cap_data}); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL w3_busy_after_stop: got %b want 0", busy); end
    endtask

    task automatic test_id_mismatch;
        logic a0, a1, a2, a3, a4;
        int wr0, oe0;
        wr0 = wr_cnt; oe0 = oe_cnt;
        bus_start;
        write_byte(8'h60, a0);
        @(negedge clk);
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL mis_busy: got %b want 0", busy); end
        write_byte(8'h12, a1);
        bus_stop; wait_q;
        vecs++; if ({a0, a1} !== 2'b00) begin errs++; $display("FAIL mis_acks: got %b want 00", {a0, a1}); end
        vecs++; if (oe_cnt != oe0) begin errs++; $display("FAIL mis_oe_cycles: got %0d want 0", oe_cnt - oe0); end
        vecs++; if (wr_cnt != wr0) begin errs++; $display("FAIL mis_wr_en: got %0d want 0", wr_cnt - wr0); end
        bus_start;
        write_byte(8'h42, a2); write_byte(8'h5C, a3); write_byte(8'hA5, a4);
        bus_stop; wait_q;
        vecs++; if ({a2, a3, a4} !== 3'b111) begin errs++; $display("FAIL mis_next_acks: got %b want 111", {a2, a3, a4}); end
        vecs++; if ((wr_cnt - wr0 != 1) || ({cap_addr, cap_data} !== 16'h5CA5)) begin
            errs++; $display("FAIL mis_next_write: got n=%0d %h want n=1 5ca5", wr_cnt - wr0, {cap_addr, cap_data});
        end
    endtask

    task automatic test_two_phase_read;
        logic a0, a1, a2, na;
        logic [7:0] d, oeb;
        int wr0;
        wr0 = wr_cnt;
        bus_start;
        write_byte(8'h42, a0); write_byte(8'h0A, a1);
        bus_stop; wait_q;
        vecs++; if ({a0, a1} !== 2'b11) begin errs++; $display("FAIL rd_phase1_acks: got %b want 11", {a0, a1}); end
        vecs++; if (rd_addr !== 8'h0A) begin errs++; $display("FAIL rd_addr_latched: got %h want 0a", rd_addr); end
        rd_data = 8'h76;
        bus_start;
        write_byte(8'h43, a2);
        read_byte(d, oeb, na);
        bus_stop; wait_q;
        vecs++; if (a2 !== 1'b1) begin errs++; $display("FAIL rd_id_ack: got %b want 1", a2); end
        vecs++; if (d !== 8'h76) begin errs++; $display("FAIL rd_bus_byte: got %h want 76", d); end
        vecs++; if (oeb !== 8'h89) begin errs++; $display("FAIL rd_oe_pattern: got %h want 89", oeb); end
        vecs++; if (na !== 1'b0) begin errs++; $display("FAIL rd_na_release: got %b want 0", na); end
        vecs++; if (wr_cnt != wr0) begin errs++; $display("FAIL rd_no_wr_en: got %0d want 0", wr_cnt - wr0); end
        vecs++; if ((rd_addr !== 8'h0A) || (busy !== 1'b0)) begin errs++; $display("FAIL rd_end_state: got addr=%h busy=%b want 0a/0", rd_addr, busy); end
    endtask

    task automatic test_partial_stop;
        logic a0, a1, a2, a3, a4;
        int wr0;
        wr0 = wr_cnt;
        bus_start;
        write_byte(8'h42, a0); write_byte(8'h20, a1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        bus_stop; wait_q;
        vecs++; if (wr_cnt != wr0) begin errs++; $display("FAIL part_no_wr_en: got %0d want 0", wr_cnt - wr0); end
        vecs++; if ({SIOD_oe, busy} !== 2'b00) begin errs++; $display("FAIL part_idle: got oe/busy=%b want 00", {SIOD_oe, busy}); end
        bus_start;
        write_byte(8'h42, a2); write_byte(8'h3A, a3); write_byte(8'h04, a4);
        bus_stop; wait_q;
        vecs++; if ({a0, a1, a2, a3, a4} !== 5'b11111) begin errs++; $display("FAIL part_acks: got %b want 11111", {a0, a1, a2, a3, a4}); end
        vecs++; if ((wr_cnt - wr0 != 1) || ({cap_addr, cap_data} !== 16'h3A04)) begin
            errs++; $display("FAIL part_next_write: got n=%0d %h want n=1 3a04", wr_cnt - wr0, {cap_addr, cap_data});
        end
    endtask

    task automatic test_repeated_start;
        logic a0, a1, a2, na;
        logic [7:0] d, oeb;
        int wr0;
        wr0 = wr_cnt;
        rd_data = 8'hC3;
        bus_start;
        write_byte(8'h42, a0); write_byte(8'h55, a1);
        bus_start;
        write_byte(8'h43, a2);
        read_byte(d, oeb, na);
        bus_stop; wait_q;
        vecs++; if ({a0, a1, a2} !== 3'b111) begin errs++; $display("FAIL sr_acks: got %b want 111", {a0, a1, a2}); end
        vecs++; if (d !== 8'hC3) begin errs++; $display("FAIL sr_read_byte: got %h want c3", d); end
        vecs++; if (rd_addr !== 8'h55) begin errs++; $display("FAIL sr_rd_addr: got %h want 55", rd_addr); end
        vecs++; if (wr_cnt != wr0) begin errs++; $display("FAIL sr_no_wr_en: got %0d want 0", wr_cnt - wr0); end
    endtask

    task automatic test_reset_mid_ack;
        logic a0, a1, a2;
        int wr0;
        bus_start;
        for (int i = 7; i >= 0; i--) send_bit(i == 6 || i == 1);  // 0x42
        m_siod = 1'b1; wait_q;
        m_sioc = 1'b1; wait_q;
        @(negedge clk);
        vecs++; if (SIOD_oe !== 1'b1) begin errs++; $display("FAIL rst_ack_driven: got %b want 1", SIOD_oe); end
        #2 rst_n = 1'b0;
        #1;
        vecs++; if ({SIOD_oe, wr_en, busy} !== 3'b000) begin errs++; $display("FAIL rst_async_ctrl: got %b want 000", {SIOD_oe, wr_en, busy}); end
        vecs++; if ({wr_addr, wr_data, rd_addr} !== 24'h000000) begin errs++; $display("FAIL rst_async_regs: got %h want 000000", {wr_addr, wr_data, rd_addr}); end
        @(negedge clk) rst_n = 1'b1;
        m_sioc = 1'b0; wait_q;
        bus_stop; wait_q;
        wr0 = wr_cnt;
        bus_start;
        write_byte(8'h42, a0); write_byte(8'h01, a1); write_byte(8'h02, a2);
        bus_stop; wait_q;
        vecs++; if ((wr_cnt - wr0 != 1) || ({cap_addr, cap_data} !== 16'h0102) || ({a0, a1, a2} !== 3'b111)) begin
            errs++; $display("FAIL rst_recovery: got n=%0d %h acks=%b want n=1 0102 111", wr_cnt - wr0, {cap_addr, cap_data}, {a0, a1, a2});
        end
    endtask

    initial begin
        test_reset;
        test_three_phase_write;
        test_id_mismatch;
        test_two_phase_read;
        test_partial_stop;
        test_repeated_start;
        test_reset_mid_ack;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
